// File: rtl/risc_mgmt_execute_ctrl_if.sv
// Execute-stage link between the core, the RISC-MGMT controller and N_EXT extensions.
// master = controller side, slave = core/extension environment side.
interface risc_mgmt_execute_ctrl_if #(parameter int N_EXT = 4);
  localparam int SELW = (N_EXT > 1) ? $clog2(N_EXT) : 1;

  logic                  ext_start;
  logic [SELW-1:0]       ext_sel;
  logic                  flush;
  logic [N_EXT-1:0]      start_oh;
  logic [N_EXT-1:0]      abort_oh;
  logic [N_EXT-1:0]      ext_busy;
  logic [N_EXT-1:0]      ext_exception;
  logic [N_EXT-1:0]      ext_reg_w;
  logic [5*N_EXT-1:0]    ext_reg_waddr;
  logic [32*N_EXT-1:0]   ext_reg_wdata;
  logic [N_EXT-1:0]      ext_branch_jump;
  logic [32*N_EXT-1:0]   ext_br_j_addr;
  logic                  core_stall;
  logic                  core_valid;
  logic                  core_reg_w;
  logic [4:0]            core_reg_waddr;
  logic [31:0]           core_reg_wdata;
  logic                  core_branch_jump;
  logic [31:0]           core_br_j_addr;
  logic                  core_exception;
  logic [1:0]            core_ex_cause;

  modport master (
    input  ext_start, ext_sel, flush, ext_busy, ext_exception, ext_reg_w,
           ext_reg_waddr, ext_reg_wdata, ext_branch_jump, ext_br_j_addr,
    output start_oh, abort_oh, core_stall, core_valid, core_reg_w, core_reg_waddr,
           core_reg_wdata, core_branch_jump, core_br_j_addr, core_exception, core_ex_cause
  );

  modport slave (
    output ext_start, ext_sel, flush, ext_busy, ext_exception, ext_reg_w,
           ext_reg_waddr, ext_reg_wdata, ext_branch_jump, ext_br_j_addr,
    input  start_oh, abort_oh, core_stall, core_valid, core_reg_w, core_reg_waddr,
           core_reg_wdata, core_branch_jump, core_br_j_addr, core_exception, core_ex_cause
  );
endinterface

// File: rtl/risc_mgmt_execute_ctrl.sv
// Execute-stage controller: start pulse, busy stall, one-cycle commit of extension results.
// Optional WAIT timeout with abort pulse enabled by RISC_MGMT_EXEC_TIMEOUT_EN.
module risc_mgmt_execute_ctrl #(
  parameter int N_EXT          = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                     CLK,
  input  logic                     nRST,
  risc_mgmt_execute_ctrl_if.master bus
);
  localparam int SELW = (N_EXT > 1) ? $clog2(N_EXT) : 1;

  typedef enum logic [1:0] {IDLE, WAIT, COMMIT} state_t;

  typedef struct packed {
    logic        exc;
    logic [1:0]  cause;
    logic        reg_w;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        bj;
    logic [31:0] baddr;
  } res_t;

  state_t          state_q, state_d;
  logic [SELW-1:0] sel_q, sel_d;
  res_t            res_q, res_d;
  logic [N_EXT-1:0] start_oh_c, abort_oh_c;
  logic            stall_c;
  logic            sel_ok;
  logic            sel_exc;

`ifdef RISC_MGMT_EXEC_TIMEOUT_EN
  logic [15:0]     cnt_q, cnt_d;
`else
  logic            unused_tmo;
  assign unused_tmo = ^TIMEOUT_CYCLES;
`endif

  assign sel_ok  = 32'(bus.ext_sel) < 32'(N_EXT);
  assign sel_exc = bus.ext_exception[sel_q];

  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    res_d      = res_q;
    start_oh_c = '0;
    abort_oh_c = '0;
    stall_c    = 1'b0;
`ifdef RISC_MGMT_EXEC_TIMEOUT_EN
    cnt_d      = '0;
`endif
    unique case (state_q)
      IDLE: begin
        if (bus.ext_start) begin
          stall_c = 1'b1;
          if (sel_ok) begin
            start_oh_c[bus.ext_sel] = 1'b1;
            sel_d                   = bus.ext_sel;
            state_d                 = WAIT;
          end else begin
            res_d       = '0;
            res_d.exc   = 1'b1;
            res_d.cause = 2'd2;
            state_d     = COMMIT;
          end
        end
      end
      WAIT: begin
        stall_c = 1'b1;
        if (!bus.ext_busy[sel_q]) begin
          // Exception suppresses side effects; address/data fields are captured regardless.
          res_d.exc   = sel_exc;
          res_d.cause = sel_exc ? 2'd1 : 2'd0;
          res_d.reg_w = bus.ext_reg_w[sel_q] & ~sel_exc;
          res_d.bj    = bus.ext_branch_jump[sel_q] & ~sel_exc;
          res_d.waddr = bus.ext_reg_waddr[5*int'(sel_q) +: 5];
          res_d.wdata = bus.ext_reg_wdata[32*int'(sel_q) +: 32];
          res_d.baddr = bus.ext_br_j_addr[32*int'(sel_q) +: 32];
          state_d     = COMMIT;
        end
`ifdef RISC_MGMT_EXEC_TIMEOUT_EN
        else if (cnt_q == 16'(TIMEOUT_CYCLES)) begin
          abort_oh_c[sel_q] = 1'b1;
          res_d             = '0;
          res_d.exc         = 1'b1;
          res_d.cause       = 2'd3;
          state_d           = COMMIT;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
`endif
      end
      COMMIT: begin
        res_d   = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (bus.flush) begin
      state_d    = IDLE;
      res_d      = '0;
      start_oh_c = '0;
      abort_oh_c = '0;
      stall_c    = 1'b0;
`ifdef RISC_MGMT_EXEC_TIMEOUT_EN
      cnt_d      = '0;
`endif
    end
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_q <= IDLE;
      sel_q   <= '0;
      res_q   <= '0;
`ifdef RISC_MGMT_EXEC_TIMEOUT_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      res_q   <= res_d;
`ifdef RISC_MGMT_EXEC_TIMEOUT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  assign bus.start_oh         = start_oh_c;
  assign bus.abort_oh         = abort_oh_c;
  assign bus.core_stall       = stall_c;
  assign bus.core_valid       = (state_q == COMMIT) && !bus.flush;
  assign bus.core_reg_w       = res_q.reg_w;
  assign bus.core_reg_waddr   = res_q.waddr;
  assign bus.core_reg_wdata   = res_q.wdata;
  assign bus.core_branch_jump = res_q.bj;
  assign bus.core_br_j_addr   = res_q.baddr;
  assign bus.core_exception   = res_q.exc;
  assign bus.core_ex_cause    = res_q.cause;
endmodule

// File: doc/risc_mgmt_execute_ctrl.md
# risc_mgmt_execute_ctrl

Core-side controller for the execute-stage link between the RISC-MGMT unit and its custom-instruction extensions. It issues a start pulse to the selected extension, stalls the core while that extension reports busy, then captures the extension's exception, register-write and branch/jump results and presents them to the core for exactly one cycle. It sits between the core execute stage and the per-extension execute blocks.

## Interface
Parameters:
- N_EXT, 4, number of attached extensions (1..16); SELW = max(1, $clog2(N_EXT))
- TIMEOUT_CYCLES, 255, WAIT-cycle limit before forced abort (1..65535); used only with timeout enabled

Ports:
- CLK  in  1  clock; all state updates on rising edge
- nRST  in  1  reset, synchronous, active-low
- ext_start  in  1  core has a custom instruction in execute; valid only in IDLE
- ext_sel  in  SELW  index of the owning extension; sampled with ext_start
- flush  in  1  core pipeline flush; kills any operation in flight
- start_oh  out  N_EXT  one-hot, single-cycle start pulse to the selected extension
- abort_oh  out  N_EXT  one-hot, single-cycle abort pulse on timeout
- ext_busy  in  N_EXT  per-extension busy
- ext_exception  in  N_EXT  per-extension exception
- ext_reg_w  in  N_EXT  per-extension register write request
- ext_reg_waddr  in  5*N_EXT  packed write addresses; extension i occupies bits [5i+4:5i]
- ext_reg_wdata  in  32*N_EXT  packed write data; extension i occupies bits [32i+31:32i]
- ext_branch_jump  in  N_EXT  per-extension branch/jump request
- ext_br_j_addr  in  32*N_EXT  packed branch/jump targets; extension i occupies bits [32i+31:32i]
- core_stall  out  1  hold the core's execute stage
- core_valid  out  1  one-cycle commit strobe
- core_reg_w, core_reg_waddr[4:0], core_reg_wdata[31:0]  out  register write to the core
- core_branch_jump, core_br_j_addr[31:0]  out  redirect to the core
- core_exception  out  1  exception to the core
- core_ex_cause  out  2  0 none, 1 extension exception, 2 illegal select, 3 timeout

## Operation
- States: IDLE, WAIT, COMMIT.
- Reset (nRST low at an edge): state becomes IDLE, timeout counter 0, result registers 0. Every output is 0 while in IDLE with ext_start low.
- IDLE:
  - When ext_start=1 and ext_sel < N_EXT: drive start_oh[ext_sel]=1 and core_stall=1 combinationally, latch sel, go to WAIT.
  - When ext_start=1 and ext_sel >= N_EXT: no start pulse, core_stall=1, load core_exception=1 with cause 2, go to COMMIT.
- WAIT:
  - core_stall=1.
  - If ext_busy[sel]=0: capture the selected extension's outputs and go to COMMIT.
  - Otherwise stay in WAIT; the timeout counter increments.
- Capture priority:
  - Exception wins: reg_w and branch_jump are forced to 0 and cause is 1.
  - Otherwise reg_w and branch_jump are both passed through; both may be 1 in the same commit.
  - The address and data fields are captured even when their enables are 0.
- COMMIT:
  - core_valid=1 and core_stall=0; the registered results are driven for exactly this one cycle.
  - Next state is always IDLE. A new ext_start is accepted no earlier than the IDLE cycle that follows.
- flush=1 in any state: next state IDLE, result registers and counter cleared, and start_oh, abort_oh, core_valid and core_stall are forced to 0 in that cycle. flush has priority over every other condition.
- ext_sel is ignored outside IDLE. Inputs from unselected extensions are never observed.

## Timing
- Minimum latency: ext_start in cycle T, WAIT in T+1 with busy=0, COMMIT (core_valid) in T+2. core_stall is high in T and T+1.
- With a k-cycle busy (busy high for k WAIT cycles): core_valid arrives in cycle T+2+k.
- Illegal select: COMMIT in T+1.
- All core_* result outputs are register outputs. start_oh and core_stall are combinational from ext_start/ext_sel in IDLE.

## Configuration
- Macro: RISC_MGMT_EXEC_TIMEOUT_EN.
- Defined:
  - A 16-bit counter counts WAIT cycles.
  - When the counter equals TIMEOUT_CYCLES and busy is still high, the block pulses abort_oh[sel] for one cycle, loads core_exception=1 with cause 3, and goes to COMMIT.
  - If busy falls in that same cycle, the normal capture wins.
- Undefined: no counter exists, abort_oh is tied to 0, WAIT lasts indefinitely, and cause 3 never occurs.

## Test plan
- Reset: hold nRST=0 for 2 edges with ext_start=1 -> all outputs 0 after reset, state IDLE.
- Single-cycle op: sel=2, busy low, reg_w=1, waddr=5, wdata=0xDEADBEEF -> start_oh=4'b0100 in T, core_valid in T+2 with reg_w=1, waddr=5, wdata=0xDEADBEEF, core_stall high in T and T+1 only.
- Multi-cycle op with exception: sel=1, busy high for 3 WAIT cycles, then exception=1, reg_w=1, branch_jump=1 -> core_valid at T+5, core_exception=1, cause=1, reg_w=0, branch_jump=0.
- Illegal select: N_EXT=3, ext_sel=3 -> no start_oh, COMMIT at T+1 with cause=2.
- Flush mid-operation: flush=1 in the second WAIT cycle -> next state IDLE, no core_valid, core_stall low in the flush cycle; a new ext_start is then accepted normally.
- Timeout (macro defined, TIMEOUT_CYCLES=4): busy held high -> abort_oh[sel] pulses once, core_valid with cause=3 follows; with the macro undefined the bench sees no commit after 1000 cycles.
